// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester A/B command handshakes, grant/busy status and the single-port memory pins.
interface mem_arbiter_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
);
   logic              req_a, wr_a, ack_a, req_b, wr_b, ack_b;
   logic              gnt_a, gnt_b, busy, mem_we, mem_re;
   logic [ADDR_W-1:0] addr_a, addr_b, mem_addr;
   logic [DATA_W-1:0] wdata_a, rdata_a, wdata_b, rdata_b, mem_din, mem_dout;
   modport slave (
      input  req_a, wr_a, addr_a, wdata_a, req_b, wr_b, addr_b, wdata_b, mem_dout,
      output ack_a, rdata_a, ack_b, rdata_b, gnt_a, gnt_b, busy, mem_we, mem_re, mem_addr, mem_din
   );
   modport master (
      output req_a, wr_a, addr_a, wdata_a, req_b, wr_b, addr_b, wdata_b, mem_dout,
      input  ack_a, rdata_a, ack_b, rdata_b, gnt_a, gnt_b, busy, mem_we, mem_re, mem_addr, mem_din
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter/sequencer for a single-port memory with 1-cycle read latency.
// Define MEM_ARB_FIXED_PRI_EN for fixed priority (A always wins a tie) instead of round-robin.
module mem_arbiter #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [2:0] {IDLE, WR, RD, CAP, DONE} state_t;
   state_t            state_q, state_d;
   logic              own_q, own_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d, rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
   logic              take, pick_b;
   assign take = (state_q == IDLE) & (bus.req_a | bus.req_b);
`ifdef MEM_ARB_FIXED_PRI_EN
   assign pick_b = bus.req_b & ~bus.req_a;
`else
   // ptr_q = 1 means B wins the next tie
   logic ptr_q;
   always_ff @(posedge clk)
      if (rst) ptr_q <= 1'b0;
      else if (take) ptr_q <= ~pick_b;
   assign pick_b = bus.req_b & (~bus.req_a | ptr_q);
`endif
   always_comb begin
      state_d   = state_q;
      own_d     = own_q;
      addr_d    = addr_q;
      din_d     = din_q;
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
      case (state_q)
         IDLE: if (take) begin
            own_d   = pick_b;
            addr_d  = pick_b ? bus.addr_b : bus.addr_a;
            din_d   = pick_b ? bus.wdata_b : bus.wdata_a;
            state_d = (pick_b ? bus.wr_b : bus.wr_a) ? WR : RD;
         end
         WR:   state_d = DONE;
         RD:   state_d = CAP;
         CAP: begin
            state_d   = DONE;
            rdata_a_d = own_q ? rdata_a_q : bus.mem_dout;
            rdata_b_d = own_q ? bus.mem_dout : rdata_b_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         own_q     <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         state_q   <= state_d;
         own_q     <= own_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
      end
   end
   assign bus.busy     = state_q != IDLE;
   assign bus.gnt_a    = bus.busy & ~own_q;
   assign bus.gnt_b    = bus.busy & own_q;
   assign bus.ack_a    = (state_q == DONE) & ~own_q;
   assign bus.ack_b    = (state_q == DONE) & own_q;
   assign bus.mem_we   = state_q == WR;
   assign bus.mem_re   = state_q == RD;
   assign bus.mem_addr = addr_q;
   assign bus.mem_din  = din_q;
   assign bus.rdata_a  = rdata_a_q;
   assign bus.rdata_b  = rdata_b_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, corner sequences and random traffic against a transaction-level model.
module tb_mem_arbiter;
`ifdef MEM_ARB_FIXED_PRI_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(3), .DATA_W(8)) bus ();
   mem_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   // simple_memory: 8 x 8, registered read data
   logic [7:0] mem [8] = '{default: 8'h00};
   logic [7:0] dout = 8'h00;
   assign bus.mem_dout = dout;
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
      if (bus.mem_re) dout <= mem[bus.mem_addr];
   end

   int cmp = 0, bad = 0;
   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      cmp++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Transaction model: a command sampled at edge n owns the memory for 2 (write) or 3 (read) cycles
   logic [7:0] mref [8] = '{default: 8'h00};
   int         k = 0, m_n = 0;
   bit         act = 1'b0, m_wr = 1'b0, m_own = 1'b0, ptr = 1'b0, mon = 1'b0;
   logic [2:0] la = 3'd0;
   logic [7:0] ld = 8'h00, rd_val = 8'h00, erd_a = 8'h00, erd_b = 8'h00;
   logic       win_b;
   assign win_b = (bus.req_a && bus.req_b) ? ptr : bus.req_b;
   always @(posedge clk) begin
      k   <= k + 1;
      mon <= 1'b1;
      if (act && k == m_n + 1) begin
         if (m_wr) mref[la] <= ld;
         else rd_val <= mref[la];
      end
      if (act && !m_wr && k == m_n + 2 && !rst) begin
         if (m_own) erd_b <= rd_val;
         else erd_a <= rd_val;
      end
      if (rst) begin
         act <= 1'b0; ptr <= 1'b0; erd_a <= 8'h00; erd_b <= 8'h00; la <= 3'd0; ld <= 8'h00;
      end else if (act) begin
         if (k == m_n + (m_wr ? 2 : 3)) act <= 1'b0;
      end else if (bus.req_a || bus.req_b) begin
         act   <= 1'b1;
         m_n   <= k;
         m_own <= win_b;
         m_wr  <= win_b ? bus.wr_b : bus.wr_a;
         la    <= win_b ? bus.addr_b : bus.addr_a;
         ld    <= win_b ? bus.wdata_b : bus.wdata_a;
         ptr   <= FIXED ? 1'b0 : !win_b;
      end
   end
   always @(negedge clk) if (mon) begin
      chk("busy", 64'(bus.busy), 64'(act));
      chk("gnt_a", 64'(bus.gnt_a), 64'(act && !m_own));
      chk("gnt_b", 64'(bus.gnt_b), 64'(act && m_own));
      chk("ack_a", 64'(bus.ack_a), 64'(act && !m_own && k == m_n + (m_wr ? 2 : 3)));
      chk("ack_b", 64'(bus.ack_b), 64'(act && m_own && k == m_n + (m_wr ? 2 : 3)));
      chk("mem_we", 64'(bus.mem_we), 64'(act && m_wr && k == m_n + 1));
      chk("mem_re", 64'(bus.mem_re), 64'(act && !m_wr && k == m_n + 1));
      chk("mem_addr", 64'(bus.mem_addr), 64'(la));
      chk("mem_din", 64'(bus.mem_din), 64'(ld));
      chk("rdata_a", 64'(bus.rdata_a), 64'(erd_a));
      chk("rdata_b", 64'(bus.rdata_b), 64'(erd_b));
   end

   typedef struct {
      bit         use_b;
      bit         wr;
      logic [2:0] addr;
      logic [7:0] wdata;
      int         lat;
      logic [7:0] rd;
   } vec_t;
   vec_t tbl [10];

   task automatic wait_idle();
      for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
      chk("idle_timeout", 64'(bus.busy), 64'(0));
   endtask

   // Issue one command, drop req right after the sampling edge, then measure ack latency
   task automatic do_cmd(input vec_t v, input string nm);
      int         got = 0;
      logic [1:0] who = 2'b00;
      logic [7:0] r = 8'h00;
      @(posedge clk); #1;
      if (v.use_b) begin
         bus.req_b = 1'b1; bus.wr_b = v.wr; bus.addr_b = v.addr; bus.wdata_b = v.wdata;
      end else begin
         bus.req_a = 1'b1; bus.wr_a = v.wr; bus.addr_a = v.addr; bus.wdata_a = v.wdata;
      end
      @(posedge clk); #1;
      bus.req_a = 1'b0; bus.req_b = 1'b0;
      bus.addr_a = 3'($urandom_range(0, 7)); bus.wdata_a = 8'($urandom_range(0, 255));
      bus.addr_b = 3'($urandom_range(0, 7)); bus.wdata_b = 8'($urandom_range(0, 255));
      for (int c = 1; c <= 6 && got == 0; c++) begin
         @(negedge clk);
         if (bus.ack_a || bus.ack_b) begin
            got = c;
            who = {bus.ack_a, bus.ack_b};
            r   = v.use_b ? bus.rdata_b : bus.rdata_a;
         end
      end
      chk({nm, "_lat"}, 64'(got), 64'(v.lat));
      chk({nm, "_owner"}, 64'(who), 64'(v.use_b ? 2'b01 : 2'b10));
      chk({nm, "_rdata"}, 64'(r), 64'(v.rd));
      wait_idle();
   endtask

   int         owners [$];
   int         both = 0, got_b = 0, late = 0;
   bit         b_seen = 1'b0;
   logic [7:0] b_first = 8'h00, b_late_rd = 8'h00;

   initial begin
      tbl = '{
         '{1'b0, 1'b1, 3'd2, 8'hA5, 2, 8'h00},
         '{1'b0, 1'b0, 3'd2, 8'h00, 3, 8'hA5},
         '{1'b1, 1'b1, 3'd5, 8'h5A, 2, 8'h00},
         '{1'b1, 1'b0, 3'd5, 8'h00, 3, 8'h5A},
         '{1'b0, 1'b0, 3'd5, 8'h00, 3, 8'h5A},
         '{1'b1, 1'b0, 3'd2, 8'h00, 3, 8'hA5},
         '{1'b0, 1'b1, 3'd7, 8'hFF, 2, 8'h5A},
         '{1'b1, 1'b1, 3'd7, 8'h11, 2, 8'hA5},
         '{1'b0, 1'b0, 3'd7, 8'h00, 3, 8'h11},
         '{1'b1, 1'b0, 3'd7, 8'h00, 3, 8'h11}
      };
      bus.req_a = 1'b1; bus.wr_a = 1'b0; bus.addr_a = 3'd0; bus.wdata_a = 8'h00;
      bus.req_b = 1'b1; bus.wr_b = 1'b0; bus.addr_b = 3'd0; bus.wdata_b = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({bus.busy, bus.gnt_a, bus.gnt_b, bus.ack_a, bus.ack_b, bus.mem_we,
                               bus.mem_re, bus.mem_addr, bus.mem_din, bus.rdata_a, bus.rdata_b}), 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;
      bus.req_a = 1'b0; bus.req_b = 1'b0;
      @(negedge clk);
      chk("first_grant", 64'({bus.gnt_a, bus.gnt_b}), 64'(2'b10));
      wait_idle();

      for (int i = 0; i < 10; i++) do_cmd(tbl[i], $sformatf("vec%0d", i));

      // Contention: A writes 4, B reads 4, both held
      @(posedge clk); #1;
      bus.req_a = 1'b1; bus.wr_a = 1'b1; bus.addr_a = 3'd4; bus.wdata_a = 8'h3C;
      bus.req_b = 1'b1; bus.wr_b = 1'b0; bus.addr_b = 3'd4;
      for (int c = 0; c < 40 && owners.size() < 6; c++) begin
         @(negedge clk);
         if (bus.ack_a && bus.ack_b) both++;
         if (bus.ack_a) owners.push_back(0);
         else if (bus.ack_b) begin
            owners.push_back(1);
            if (!b_seen) begin b_seen = 1'b1; b_first = bus.rdata_b; end
         end
      end
      @(posedge clk); #1;
      bus.req_a = 1'b0;
      for (int c = 0; c < 10 && got_b == 0; c++) begin
         @(negedge clk);
         if (bus.ack_b) begin got_b = 1; b_late_rd = bus.rdata_b; end
      end
      @(posedge clk); #1;
      bus.req_b = 1'b0;
      wait_idle();
      chk("contention_count", 64'(owners.size()), 64'(6));
      for (int i = 0; i < owners.size(); i++)
         chk($sformatf("contention_owner%0d", i), 64'(owners[i]), 64'(FIXED ? 0 : i % 2));
      chk("contention_both_ack", 64'(both), 64'(0));
      chk("contention_b_first_read", 64'(b_first), 64'(FIXED ? 8'h00 : 8'h3C));
      chk("b_after_a_drop", 64'(got_b), 64'(1));
      chk("b_after_a_drop_rdata", 64'(b_late_rd), 64'(8'h3C));

      // Reset while in CAP aborts the read
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rdata_a", 64'(bus.rdata_a), 64'(0));
      @(posedge clk); #1;
      bus.req_a = 1'b1; bus.wr_a = 1'b0; bus.addr_a = 3'd2;
      @(posedge clk); #1;
      bus.req_a = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("in_cap", 64'({bus.busy, bus.gnt_a, bus.mem_re}), 64'(3'b110));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("cap_abort", 64'({bus.busy, bus.ack_a, bus.rdata_a}), 64'(0));
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.ack_a || bus.ack_b) late++;
      end
      chk("no_late_ack", 64'(late), 64'(0));
      do_cmd('{1'b0, 1'b0, 3'd2, 8'h00, 3, 8'hA5}, "read_after_abort");

      // Random traffic with occasional resets, checked cycle by cycle by the model
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         rst         = ($urandom_range(0, 50) == 0);
         bus.req_a   = 1'($urandom_range(0, 1));
         bus.wr_a    = 1'($urandom_range(0, 1));
         bus.addr_a  = 3'($urandom_range(0, 7));
         bus.wdata_a = 8'($urandom_range(0, 255));
         bus.req_b   = 1'($urandom_range(0, 1));
         bus.wr_b    = 1'($urandom_range(0, 1));
         bus.addr_b  = 3'($urandom_range(0, 7));
         bus.wdata_b = 8'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
      rst = 1'b0; bus.req_a = 1'b0; bus.req_b = 1'b0;
      wait_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", cmp, bad);
      $fatal(1);
   end
endmodule
